// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers:
// state encoding and per-boundary NOP payloads.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKIDF = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        FULL  = ST_FULL,
        SKIDF = ST_SKIDF
    } state_t;

    // IF/ID bubble: {pc4, inst} both zero
    localparam logic [63:0] NOP_IFID = {32'h0, 32'h0};
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bundle of one stage
// boundary; master is the environment, slave the stage.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous
// active-low clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic stage register with stall, flush, NOP
// bubbles and an optional skid entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 64,
    parameter int                SKID    = 1,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_IFID),
    parameter int                CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 clrn,
    pipe_stage_reg_if.slave      bus,
    input  logic                 stall,
    input  logic                 flush,
    output logic [1:0]           occ,
    output logic [CNT_W-1:0]     stall_cnt
);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_n;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_n;
    logic              rdy_q;
    logic              alive;
    logic              in_ready;
    logic              enq;
    logic              deq;
    logic              stall_inc;

    assign deq = bus.out_valid & bus.out_ready & ~stall;
    assign enq = bus.in_valid & in_ready;

    // skid mode: ready comes straight from a flop
    assign in_ready = (SKID != 0) ? rdy_q
                    : alive & (~bus.out_valid | deq);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_data  = main_q;
    assign occ           = state;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = NOP_VAL;
            skid_n  = NOP_VAL;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (enq) begin
                        state_n = FULL;
                        main_n  = bus.in_data;
                    end
                end
                FULL: begin
                    if (enq && deq) begin
                        main_n  = bus.in_data;
                    end else if (enq) begin
                        state_n = SKIDF;
                        skid_n  = bus.in_data;
                    end else if (deq) begin
                        state_n = EMPTY;
                        main_n  = NOP_VAL;
                    end
                end
                SKIDF: begin
                    if (deq) begin
                        state_n = FULL;
                        main_n  = skid_q;
                        skid_n  = NOP_VAL;
                    end
                end
                default: begin
                    state_n = EMPTY;
                    main_n  = NOP_VAL;
                    skid_n  = NOP_VAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state  <= EMPTY;
            main_q <= NOP_VAL;
            skid_q <= NOP_VAL;
            rdy_q  <= 1'b0;
            alive  <= 1'b0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
            rdy_q  <= (state_n != SKIDF);
            alive  <= 1'b1;
        end
    end

    assign stall_inc = bus.out_valid & stall & ~flush;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (stall_inc),
        .cnt  (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register that generalises the fixed IF/ID latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width payload with a valid/ready handshake.
- Honours the hazard unit's stall and the branch unit's flush.
- Inserts NOP bubbles, and optionally holds a one-entry skid buffer so in_ready is fully registered.
- Counts stall cycles for performance debug.

Parameters:
DATA_W, 64, payload width (e.g. pc4 + inst = 64).
SKID, 1, 1 = two-entry stage with skid register and registered in_ready; 0 = single register with combinational in_ready.
NOP_VAL, 0, payload value driven on out_data when the stage holds no valid entry (reset, flush, bubble).
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  input  1  rising-edge clock
clrn  input  1  synchronous active-low reset
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept an entry this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  stage holds a valid entry
out_ready  input  1  downstream can consume
out_data  output  DATA_W  payload of the head entry; NOP_VAL when out_valid=0
stall  input  1  hazard hold; blocks dequeue even if out_ready=1
flush  input  1  discard all held entries this edge
occ  output  2  entries held (0..2; max 1 when SKID=0)
stall_cnt  output  CNT_W  cycles with out_valid=1 and stall=1, saturating

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-low on clrn.
- All state updates occur on posedge clk only.
- Handshake definitions:
  - enq = in_valid & in_ready
  - deq = out_valid & out_ready & ~stall
- Reset (clrn=0 at an edge):
  - state EMPTY; main and skid registers = NOP_VAL
  - out_valid=0, occ=0, stall_cnt=0
  - in_ready=0 while clrn=0; in_ready=1 from the first edge after release
- Latency: one cycle from enq to out_valid. Sustained throughput: one entry per cycle with out_ready=1 and stall=0.
- States for SKID=1 (FSM EMPTY/FULL/SKIDF):
  - EMPTY: in_ready=1. enq -> FULL, main<=in_data.
  - FULL: in_ready=1.
    - enq&deq -> FULL, main<=in_data.
    - enq&~deq -> SKIDF, skid<=in_data.
    - deq&~enq -> EMPTY, main<=NOP_VAL.
    - neither -> hold.
  - SKIDF: in_ready=0. deq -> FULL, main<=skid, skid<=NOP_VAL; else hold.
  - in_ready is a registered function of state only. It has no combinational path from out_ready or stall.
- SKID=0 (states EMPTY/FULL only):
  - in_ready = ~out_valid | deq (combinational)
  - enq&deq replaces main; deq alone loads NOP_VAL.
- Ordering: strict FIFO; main is always the head. No entry is duplicated or dropped except by flush.
- Flush has priority over stall, enq and deq:
  - next state EMPTY; main and skid <= NOP_VAL; occ=0.
  - An entry handshaked in the flush cycle is discarded.
  - stall_cnt is not cleared by flush.
- Stall with out_valid=1: main/skid hold exactly. Upstream may still enq into free slots (FULL -> SKIDF when SKID=1).
- Stall with out_valid=0: no effect on state.
- stall_cnt increments when out_valid & stall & ~flush, and saturates at 2^CNT_W-1 (no wrap).
- occ = 0/1/2 for EMPTY/FULL/SKIDF.
- out_data = main register. out_valid = (state != EMPTY).
- Reset mid-operation: all entries lost; outputs as in reset the following cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKIDF=2'd2
  - per-stage default NOP payload constants (e.g. a 64-bit IF/ID NOP = {32'h0, 32'h0})
- One natural sub-module: sat_counter (parametrised CNT_W, synchronous active-low clear, saturating increment), used for stall_cnt.
- The FSM and the data registers stay in pipe_stage_reg.

Test Plan:
- Reset then stream 4 entries 0xA..0xD, out_ready=1, stall=0, SKID=1 -> out_data 0xA..0xD on consecutive cycles one cycle after each enq; occ stays 1; in_ready=1 throughout.
- Enq 0x11, 0x22, 0x33 with out_ready=0 -> after 2 enqs occ=2, in_ready=0, 0x33 held upstream. Release out_ready -> 0x11, 0x22, 0x33 in order, no loss.
- Entry 0x55 held, stall=1 for 5 cycles with out_ready=1 -> out_data stays 0x55, stall_cnt=5. Stall drops -> 0x55 consumed once.
- occ=2 with 0x66/0x77 and flush=1 with in_valid=1 (0x88) same cycle -> next cycle out_valid=0, out_data=NOP_VAL, occ=0, 0x88 discarded, stall_cnt unchanged.
- CNT_W=3, hold stall=1 with valid entry for 10 cycles -> stall_cnt saturates at 7.
- SKID=0, occ=1 with 0x99, out_ready=1 and in_valid=1 (0xAA) same cycle -> in_ready=1 combinationally, next cycle out_data=0xAA. Then clrn=0 mid-stream for 1 edge -> out_valid=0, occ=0, stall_cnt=0.
